// File: rtl/pattern_sync_pkg.sv
// Shared types and widths for the pattern timing front-end and its raster counter.
package pattern_sync_pkg;

  localparam int DATA_W  = 12;
  localparam int MODE_W  = 3;
  localparam int DELTA_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HBLANK = 2'd2,
    VBLANK = 2'd3
  } state_t;

  typedef struct packed {
    logic [MODE_W-1:0]  mode;
    logic [DATA_W-1:0]  const_val;
    logic [DELTA_W-1:0] dx;
    logic [DELTA_W-1:0] dy;
  } cfg_t;

  // Counter width for a modulus of n; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pattern_sync_gen_raster_counter.sv
// Pixel/line raster position counter with end-of-line and end-of-frame strobes.
module raster_counter #(
  parameter int H_TOTAL = 80,
  parameter int L_TOTAL = 50,
  parameter int PIX_W   = 7,
  parameter int LINE_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  output logic [PIX_W-1:0]  pix,
  output logic [LINE_W-1:0] line,
  output logic              pix_wrap,
  output logic              frame_wrap,
  output logic              frame_pre_last
);

  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(H_TOTAL - 1);
  localparam logic [PIX_W-1:0]  PIX_PRE   = PIX_W'(H_TOTAL - 2);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(L_TOTAL - 1);

  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              line_last;

  always_comb begin
    line_last      = (line_q == LINE_LAST);
    pix_wrap       = (pix_q == PIX_LAST);
    frame_wrap     = pix_wrap && line_last;
    // Lets the owner register a strobe that lands exactly on the last frame cycle.
    frame_pre_last = (pix_q == PIX_PRE) && line_last;

    pix_d  = pix_q;
    line_d = line_q;
    if (clear) begin
      pix_d  = '0;
      line_d = '0;
    end else if (advance) begin
      if (pix_wrap) begin
        pix_d  = '0;
        line_d = line_last ? '0 : line_q + 1'b1;
      end else begin
        pix_d = pix_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q  <= '0;
      line_q <= '0;
    end else begin
      pix_q  <= pix_d;
      line_q <= line_d;
    end
  end

  assign pix  = pix_q;
  assign line = line_q;

endmodule

// File: rtl/pattern_sync_gen.sv
// Frame/line timing generator that shadows pattern configuration at each frame start.
// state  | meaning
// IDLE   | waiting for enable, raster held at 0
// ACTIVE | active pixels of an active line
// HBLANK | horizontal blanking of an active line
// VBLANK | blank lines at the end of the frame
module pattern_sync_gen
  import pattern_sync_pkg::*;
#(
  parameter int H_ACTIVE = 64,
  parameter int H_BLANK  = 16,
  parameter int V_LINES  = 48,
  parameter int V_BLANK  = 2,
  parameter int FCNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [MODE_W-1:0]  mode_in,
  input  logic [DATA_W-1:0]  const_in,
  input  logic [DELTA_W-1:0] dx_in,
  input  logic [DELTA_W-1:0] dy_in,
  output logic               f_sync,
  output logic               sync,
  output logic               line_active,
  output logic [DATA_W-1:0]  pix_idx,
  output logic [DATA_W-1:0]  line_idx,
  output logic [MODE_W-1:0]  Mode,
  output logic [DATA_W-1:0]  constVal,
  output logic [DELTA_W-1:0] X,
  output logic [DELTA_W-1:0] Y,
  output logic               frame_done,
  output logic [FCNT_W-1:0]  frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int L_TOTAL = V_LINES + V_BLANK;
  localparam int PIX_W   = cnt_width(H_TOTAL);
  localparam int LINE_W  = cnt_width(L_TOTAL);
  localparam logic [PIX_W-1:0]  PIX_ACT_LAST  = PIX_W'(H_ACTIVE - 1);
  localparam logic [LINE_W-1:0] LINE_ACT_LAST = LINE_W'(V_LINES - 1);

  state_t              state_q, state_d;
  cfg_t                cfg_q, cfg_d;
  logic                f_sync_q, f_sync_d;
  logic                sync_q, sync_d;
  logic                line_active_q, line_active_d;
  logic                frame_done_q, frame_done_d;
  logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;

  logic [PIX_W-1:0]    pix_cnt;
  logic [LINE_W-1:0]   line_cnt;
  logic                pix_wrap, frame_wrap, frame_pre_last;
  logic                start;
  logic                next_pix_zero, next_line_zero;

  raster_counter #(
    .H_TOTAL (H_TOTAL),
    .L_TOTAL (L_TOTAL),
    .PIX_W   (PIX_W),
    .LINE_W  (LINE_W)
  ) u_raster (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear          (state_q == IDLE),
    .advance        (state_q != IDLE),
    .pix            (pix_cnt),
    .line           (line_cnt),
    .pix_wrap       (pix_wrap),
    .frame_wrap     (frame_wrap),
    .frame_pre_last (frame_pre_last)
  );

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    start   = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) start = 1'b1;
      end
      default: begin
        if (frame_wrap) begin
          if (enable) start = 1'b1;
          else        state_d = IDLE;
        end else if (pix_wrap) begin
          state_d = (line_cnt < LINE_ACT_LAST) ? ACTIVE : VBLANK;
        end else if (state_q == ACTIVE && pix_cnt == PIX_ACT_LAST) begin
          state_d = HBLANK;
        end
      end
    endcase

    if (start) begin
      state_d = ACTIVE;
      cfg_d   = '{mode: mode_in, const_val: const_in, dx: dx_in, dy: dy_in};
    end

    // Strobes are registered, so decode them from where the raster lands next.
    next_pix_zero  = (state_q == IDLE) || pix_wrap;
    next_line_zero = (state_q == IDLE) || frame_wrap;
    line_active_d  = (state_d == ACTIVE);
    sync_d         = line_active_d && next_pix_zero;
    f_sync_d       = sync_d && next_line_zero;
    frame_done_d   = (state_q != IDLE) && frame_pre_last;
    frame_cnt_d    = frame_cnt_q + FCNT_W'(frame_done_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cfg_q         <= '0;
      f_sync_q      <= 1'b0;
      sync_q        <= 1'b0;
      line_active_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      cfg_q         <= cfg_d;
      f_sync_q      <= f_sync_d;
      sync_q        <= sync_d;
      line_active_q <= line_active_d;
      frame_done_q  <= frame_done_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign f_sync      = f_sync_q;
  assign sync        = sync_q;
  assign line_active = line_active_q;
  assign frame_done  = frame_done_q;
  assign frame_cnt   = frame_cnt_q;
  assign pix_idx     = DATA_W'(pix_cnt);
  assign line_idx    = DATA_W'(line_cnt);
  assign Mode        = cfg_q.mode;
  assign constVal    = cfg_q.const_val;
  assign X           = cfg_q.dx;
  assign Y           = cfg_q.dy;

endmodule

// File: tb/tb_pattern_sync_gen.sv
// Bench for pattern_sync_gen: a default-geometry instance and a tiny 2+1 x 1+0 instance with a 4-bit frame counter.
module tb_pattern_sync_gen;

  typedef struct packed {
    logic        fs, sy, la, fd;
    logic [11:0] pix, line;
    logic [2:0]  mode;
    logic [11:0] cv;
    logic [1:0]  x, y;
    logic [15:0] fcnt;
  } obs_t;

  logic clk = 1'b0;
  always #8 clk = ~clk;

  logic        rst_n_a [2];
  logic        en_a    [2];
  logic [2:0]  mode_a  [2];
  logic [11:0] cv_a    [2];
  logic [1:0]  dx_a    [2];
  logic [1:0]  dy_a    [2];

  logic        fs0, sy0, la0, fd0, fs1, sy1, la1, fd1;
  logic [11:0] pix0, line0, cv0, pix1, line1, cv1;
  logic [2:0]  mode0, mode1;
  logic [1:0]  x0, y0, x1, y1;
  logic [15:0] fc0;
  logic [3:0]  fc1;

  pattern_sync_gen u_dflt (
    .clk(clk), .rst_n(rst_n_a[0]), .enable(en_a[0]), .mode_in(mode_a[0]),
    .const_in(cv_a[0]), .dx_in(dx_a[0]), .dy_in(dy_a[0]),
    .f_sync(fs0), .sync(sy0), .line_active(la0), .pix_idx(pix0), .line_idx(line0),
    .Mode(mode0), .constVal(cv0), .X(x0), .Y(y0), .frame_done(fd0), .frame_cnt(fc0)
  );

  pattern_sync_gen #(.H_ACTIVE(2), .H_BLANK(1), .V_LINES(1), .V_BLANK(0), .FCNT_W(4)) u_small (
    .clk(clk), .rst_n(rst_n_a[1]), .enable(en_a[1]), .mode_in(mode_a[1]),
    .const_in(cv_a[1]), .dx_in(dx_a[1]), .dy_in(dy_a[1]),
    .f_sync(fs1), .sync(sy1), .line_active(la1), .pix_idx(pix1), .line_idx(line1),
    .Mode(mode1), .constVal(cv1), .X(x1), .Y(y1), .frame_done(fd1), .frame_cnt(fc1)
  );

  obs_t obs [2];
  assign obs[0] = {fs0, sy0, la0, fd0, pix0, line0, mode0, cv0, x0, y0, fc0};
  assign obs[1] = {fs1, sy1, la1, fd1, pix1, line1, mode1, cv1, x1, y1, 12'd0, fc1};

  int total = 0;
  int bad   = 0;

  // Model: a frame is just a cycle count t since frame start; position follows from t.
  bit          m_run [2];
  int          m_t   [2];
  int          m_fc  [2];
  logic [18:0] m_cfg [2];

  task automatic m_clear(input int k);
    m_run[k] = 0; m_t[k] = 0; m_fc[k] = 0; m_cfg[k] = '0;
  endtask

  task automatic m_step(input int k, input int frame_len);
    if (!m_run[k]) begin
      if (en_a[k]) begin
        m_run[k] = 1; m_t[k] = 0;
        m_cfg[k] = {mode_a[k], cv_a[k], dx_a[k], dy_a[k]};
      end
    end else if (m_t[k] == frame_len - 1) begin
      m_fc[k]++;
      m_t[k] = 0;
      if (en_a[k]) m_cfg[k] = {mode_a[k], cv_a[k], dx_a[k], dy_a[k]};
      else         m_run[k] = 0;
    end else begin
      m_t[k]++;
    end
  endtask

  function automatic obs_t m_exp(input int k, input int ha, input int ht, input int vl,
                                 input int lt, input int fw);
    obs_t e;
    int p, l, f;
    e = '0;
    p = m_run[k] ? m_t[k] % ht : 0;
    l = m_run[k] ? m_t[k] / ht : 0;
    f = m_fc[k] % (1 << fw);
    e.pix  = p[11:0];
    e.line = l[11:0];
    e.la   = m_run[k] && (p < ha) && (l < vl);
    e.sy   = e.la && (p == 0);
    e.fs   = e.sy && (l == 0);
    e.fd   = m_run[k] && (m_t[k] == ht * lt - 1);
    {e.mode, e.cv, e.x, e.y} = m_cfg[k];
    e.fcnt = f[15:0];
    return e;
  endfunction

  always @(posedge clk or negedge rst_n_a[0])
    if (!rst_n_a[0]) m_clear(0); else m_step(0, 80 * 50);

  always @(posedge clk or negedge rst_n_a[1])
    if (!rst_n_a[1]) m_clear(1); else m_step(1, 3);

  always @(negedge clk) begin
    obs_t e0, e1;
    e0 = m_exp(0, 64, 80, 48, 50, 16);
    e1 = m_exp(1, 2, 3, 1, 1, 4);
    total++;
    if (obs[0] !== e0) begin
      bad++;
      $display("FAIL model_dflt t=%0t act=%h exp=%h", $time, obs[0], e0);
    end
    total++;
    if (obs[1] !== e1) begin
      bad++;
      $display("FAIL model_small t=%0t act=%h exp=%h", $time, obs[1], e1);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  int cyc, nsync, nfs, nfd;

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n_a[k] = 1'b0; en_a[k] = 1'b0; mode_a[k] = '0;
      cv_a[k] = '0; dx_a[k] = '0; dy_a[k] = '0;
    end
    repeat (3) @(negedge clk);

    // Tiny geometry: frame of 3 cycles, 4-bit frame counter wrap.
    rst_n_a[1] = 1'b1;
    @(negedge clk);
    chk("s_idle_la", la1, 0);
    mode_a[1] = 3'd6; cv_a[1] = 12'h5A5; en_a[1] = 1'b1;
    nfd = 0;
    for (int i = 0; i <= 50; i++) begin
      @(negedge clk);
      if (i < 3) begin
        chk($sformatf("s_la_%0d", i), la1, (i < 2) ? 1 : 0);
        chk($sformatf("s_fs_%0d", i), fs1, (i == 0) ? 1 : 0);
        chk($sformatf("s_fd_%0d", i), fd1, (i == 2) ? 1 : 0);
      end
      if (i == 3)  chk("s_fs_repeat", fs1, 1);
      if (i == 47) chk("s_fcnt15", fc1, 15);
      if (i == 48) chk("s_fcnt_wrap0", fc1, 0);
      if (fd1) nfd++;
      if (i == 50) en_a[1] = 1'b0;
    end
    chk("s_nframes", nfd, 17);
    @(negedge clk);
    chk("s_fcnt_end", fc1, 1);
    chk("s_idle_after", {la1, fs1, pix1}, 0);

    // Default geometry.
    rst_n_a[0] = 1'b1;
    @(negedge clk);
    chk("d_reset_state", {fs0, sy0, la0, fd0, pix0, line0, mode0, cv0, fc0}, 0);
    mode_a[0] = 3'd2; cv_a[0] = 12'hABC; dx_a[0] = 2'd1; dy_a[0] = 2'd3; en_a[0] = 1'b1;
    @(negedge clk);
    chk("d_first_fs", {fs0, sy0, la0}, 3'b111);
    chk("d_first_pos", {pix0, line0}, 0);
    chk("d_first_cfg", {mode0, cv0, x0, y0}, {3'd2, 12'hABC, 2'd1, 2'd3});
    cyc = 0; nsync = 1; nfs = 1;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1000) begin
        mode_a[0] = 3'd5; cv_a[0] = 12'h123;
      end
      if (cyc == 2000) chk("d_cfg_held", {mode0, cv0}, {3'd2, 12'hABC});
      if (sy0) nsync++;
      if (fs0) nfs++;
    end while (!fd0 && cyc < 5000);
    chk("d_frame_done_at", cyc, 3999);
    chk("d_nsync", nsync, 48);
    chk("d_nfsync", nfs, 1);
    @(negedge clk);
    chk("d_next_fs", fs0, 1);
    chk("d_new_cfg", {mode0, cv0}, {3'd5, 12'h123});
    chk("d_fcnt1", fc0, 1);

    cyc = 0;
    do begin @(negedge clk); cyc++; end while (line0 != 12'd10 && cyc < 2000);
    chk("d_wait_line10", line0, 10);
    en_a[0] = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!fd0 && cyc < 5000);
    chk("d_drop_done", fd0, 1);
    @(negedge clk);
    chk("d_idle_out", {fs0, la0, pix0, line0}, 0);
    chk("d_fcnt2", fc0, 2);
    nfs = 0;
    repeat (100) begin @(negedge clk); if (fs0) nfs++; end
    chk("d_idle_nofs", nfs, 0);
    chk("d_idle_fcnt", fc0, 2);

    en_a[0] = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end
    while (!(line0 == 12'd20 && pix0 == 12'd30) && cyc < 5000);
    chk("d_wait_l20p30", {line0, pix0}, {12'd20, 12'd30});
    #3 rst_n_a[0] = 1'b0;
    #1 chk("d_async_rst", {fs0, sy0, la0, fd0, pix0, line0, mode0, cv0, x0, y0, fc0}, 0);
    @(negedge clk);
    rst_n_a[0] = 1'b1;
    @(negedge clk);
    chk("d_restart_fs", {fs0, sy0, la0}, 3'b111);
    chk("d_restart_pos", {pix0, line0, fc0}, 0);
    chk("d_restart_cfg", {mode0, cv0}, {3'd5, 12'h123});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
